// File: rtl/vga_game_pkg.sv
// vga_game_pkg
// Shared encodings for the game front end: screen states, decoded commands,
// PS/2 scan codes and sprite bus geometry. Also holds the saturating adder
// used by the score path.
package vga_game_pkg;

  typedef enum logic [1:0] {
    SCR_TITLE = 2'd0,
    SCR_PLAY  = 2'd1,
    SCR_PAUSE = 2'd2,
    SCR_OVER  = 2'd3
  } screen_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_ENTER = 2'd1,
    CMD_PAUSE = 2'd2,
    CMD_ESC   = 2'd3
  } cmd_t;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  localparam int SPRITE_X_W   = 10;
  localparam int SPRITE_Y_W   = 9;
  localparam int SPRITE_COUNT = 4;
  localparam int SPRITE_X_BUS = SPRITE_X_W * SPRITE_COUNT;
  localparam int SPRITE_Y_BUS = SPRITE_Y_W * SPRITE_COUNT;

  // a + b clamped to limit; the 10-bit sum keeps the carry visible
  function automatic logic [8:0] satAdd(input logic [8:0] a,
                                        input logic [8:0] b,
                                        input logic [8:0] limit);
    logic [9:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, limit}) return limit;
    return sum[8:0];
  endfunction

endpackage

// File: rtl/ps2_cmd_decoder.sv
// ps2_cmd_decoder
// Turns the PS/2 byte stream into game commands. A break prefix (F0) swallows
// the byte that follows it, so key releases never issue commands. The
// extended prefix (E0) is dropped without remembering anything, so an
// extended make code decodes like its plain counterpart.
// Ports:
//   iVGA_CLK   in   pixel clock
//   rst        in   synchronous reset, active-high
//   key_valid  in   strobe, key_code holds a new byte
//   key_code   in   8-bit scan code
//   cmd_valid  out  combinational strobe alongside key_valid
//   cmd        out  decoded command while cmd_valid is high
module ps2_cmd_decoder
  import vga_game_pkg::*;
(
  input  logic       iVGA_CLK,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       cmd_valid,
  output cmd_t       cmd
);

  logic break_pend;

  always_ff @(posedge iVGA_CLK) begin
    if (rst) begin
      break_pend <= 1'b0;
    end else if (key_valid) begin
      if (break_pend)                  break_pend <= 1'b0;
      else if (key_code == KEY_BREAK)  break_pend <= 1'b1;
    end
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd       = CMD_NONE;
    if (key_valid && !break_pend) begin
      case (key_code)
        KEY_ENTER: begin cmd_valid = 1'b1; cmd = CMD_ENTER; end
        KEY_P:     begin cmd_valid = 1'b1; cmd = CMD_PAUSE; end
        KEY_ESC:   begin cmd_valid = 1'b1; cmd = CMD_ESC;   end
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/frame_update_controller.sv
// frame_update_controller
// Owns the screen state machine, the two player scores and the frame-stable
// copy of the sprite positions. Every visible change is committed on the
// falling edge of vsync, so the renderer never sees a change mid-frame.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   TITLE     | title screen, sprites parked at reset positions
//   PLAY      | game running, sprites follow inputs, pickups score
//   PAUSE     | game frozen, sprites and scores hold
//   OVER      | a player reached WIN_SCORE, winner latched
//
// Ports:
//   iVGA_CLK      in   pixel clock, the only clock
//   rst           in   synchronous reset, active-high
//   iVS           in   vsync, active-low
//   key_valid     in   PS/2 byte strobe
//   key_code      in   PS/2 byte
//   sprite_x_in   in   live x positions {pu1,pu0,p1,p0}
//   sprite_y_in   in   live y positions, same order
//   pickup_p0/p1  in   one-cycle powerup pickup pulses
//   frame_start   out  pulse on the cycle after each vsync fall
//   sprite_x_out  out  frame-stable x positions
//   sprite_y_out  out  frame-stable y positions
//   screenReg     out  current screen
//   score0/1      out  scores, saturating at WIN_SCORE
//   winner        out  {p1 won, p0 won}
//   frame_count   out  frames elapsed in PLAY, wrapping
module frame_update_controller
  import vga_game_pkg::*;
#(
  parameter logic [8:0]              WIN_SCORE      = 9'd100,
  parameter logic [SPRITE_X_BUS-1:0] SPRITE_RESET_X = 40'd0,
  parameter logic [SPRITE_Y_BUS-1:0] SPRITE_RESET_Y = 36'd0
) (
  input  logic                    iVGA_CLK,
  input  logic                    rst,
  input  logic                    iVS,
  input  logic                    key_valid,
  input  logic [7:0]              key_code,
  input  logic [SPRITE_X_BUS-1:0] sprite_x_in,
  input  logic [SPRITE_Y_BUS-1:0] sprite_y_in,
  input  logic                    pickup_p0,
  input  logic                    pickup_p1,
  output logic                    frame_start,
  output logic [SPRITE_X_BUS-1:0] sprite_x_out,
  output logic [SPRITE_Y_BUS-1:0] sprite_y_out,
  output logic [1:0]              screenReg,
  output logic [8:0]              score0,
  output logic [8:0]              score1,
  output logic [1:0]              winner,
  output logic [15:0]             frame_count
);

  screen_t    screenState, screenNext;
  cmd_t       pending_cmd;
  cmd_t       dec_cmd;
  logic       dec_valid;
  logic       vs_q;
  logic       frameEdge;
  logic       inPlay;
  logic       p0Win, p1Win;
  logic       newGame;
  logic [1:0] winnerNext;
  logic [8:0] pend0, pend1;

  ps2_cmd_decoder u_decoder (
    .iVGA_CLK  (iVGA_CLK),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .cmd_valid (dec_valid),
    .cmd       (dec_cmd)
  );

  // vs_q resets low so a vsync already low out of reset is not taken as a fall
  assign frameEdge = vs_q && !iVS;
  assign inPlay    = (screenState == SCR_PLAY);
  assign p0Win     = (score0 == WIN_SCORE);
  assign p1Win     = (score1 == WIN_SCORE);
  assign screenReg = screenState;
  assign newGame   = frameEdge && (screenState == SCR_TITLE) && (screenNext == SCR_PLAY);

  always_ff @(posedge iVGA_CLK) begin
    if (rst) screenState <= SCR_TITLE;
    else     screenState <= screenNext;
  end

  // Esc beats everything, then a win, then the ordinary per-state commands.
  always_comb begin
    screenNext = screenState;
    winnerNext = winner;
    if (frameEdge) begin
      if (pending_cmd == CMD_ESC) begin
        screenNext = SCR_TITLE;
      end else begin
        case (screenState)
          SCR_TITLE: if (pending_cmd == CMD_ENTER) screenNext = SCR_PLAY;
          SCR_PLAY: begin
            if (p0Win || p1Win) begin
              screenNext = SCR_OVER;
              winnerNext = {p1Win, p0Win};
            end else if (pending_cmd == CMD_PAUSE) begin
              screenNext = SCR_PAUSE;
            end
          end
          SCR_PAUSE: if (pending_cmd == CMD_PAUSE) screenNext = SCR_PLAY;
          SCR_OVER:  if (pending_cmd == CMD_ENTER) screenNext = SCR_TITLE;
          default:   screenNext = SCR_TITLE;
        endcase
      end
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (rst) begin
      vs_q        <= 1'b0;
      frame_start <= 1'b0;
      pending_cmd <= CMD_NONE;
      score0      <= 9'd0;
      score1      <= 9'd0;
      winner      <= 2'b00;
      frame_count <= 16'd0;
      pend0       <= 9'd0;
      pend1       <= 9'd0;
    end else begin
      vs_q        <= iVS;
      frame_start <= frameEdge;

      // a command arriving on the edge cycle survives into the next frame
      if (dec_valid)      pending_cmd <= dec_cmd;
      else if (frameEdge) pending_cmd <= CMD_NONE;

      if (newGame) begin
        score0      <= 9'd0;
        score1      <= 9'd0;
        winner      <= 2'b00;
        frame_count <= 16'd0;
      end else begin
        winner <= winnerNext;
        if (frameEdge && inPlay) begin
          score0      <= satAdd(score0, pend0, WIN_SCORE);
          score1      <= satAdd(score1, pend1, WIN_SCORE);
          frame_count <= frame_count + 16'd1;
        end
      end

      // pickups accumulate over the frame and are folded in at the next edge
      if (frameEdge)              pend0 <= {8'd0, pickup_p0 && inPlay};
      else if (pickup_p0 && inPlay) pend0 <= satAdd(pend0, 9'd1, WIN_SCORE);
      if (frameEdge)              pend1 <= {8'd0, pickup_p1 && inPlay};
      else if (pickup_p1 && inPlay) pend1 <= satAdd(pend1, 9'd1, WIN_SCORE);
    end
  end

  // Sprite shadows follow the screen being entered, so the first frame of
  // PLAY already shows live positions and TITLE/OVER park them immediately.
  always_ff @(posedge iVGA_CLK) begin
    if (rst) begin
      sprite_x_out <= SPRITE_RESET_X;
      sprite_y_out <= SPRITE_RESET_Y;
    end else if (frameEdge) begin
      case (screenNext)
        SCR_PLAY: begin
          sprite_x_out <= sprite_x_in;
          sprite_y_out <= sprite_y_in;
        end
        SCR_PAUSE: ;
        default: begin
          sprite_x_out <= SPRITE_RESET_X;
          sprite_y_out <= SPRITE_RESET_Y;
        end
      endcase
    end
  end

endmodule
